fft_mag_streamer: RTL

- Sits between the FFT core and the spectral-flux stage.
- Accepts complex FFT bins on a valid/ready stream with sop/eop framing and computes |X|^2 = re^2 + im^2 in a 2-stage pipeline.
- Emits exactly N mag_valid beats per frame, with bin index and a frame_done pulse, on the mag_valid/mag_sq interface the flux stage consumes.
- Repairs malformed frames: short frames are zero-padded, long frames are truncated. Both raise sticky error flags.

---
 rtl/audio_pkg.sv | 14 +
 rtl/mag_sq_pipe.sv | 70 +++++++
 rtl/fft_mag_streamer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared defaults and types for the FFT magnitude streamer and its squaring pipe.
package audio_pkg;

  localparam int DEF_N          = 1024;
  localparam int DEF_IN_W       = 32;
  localparam int DEF_W          = 64;
  localparam int DEF_BIN_LENGTH = 10;
  localparam int DEF_GAP_CYCLES = 4;

  typedef enum logic [2:0] {IDLE, STREAM, PAD, DROP, GAP} state_t;

  typedef logic [DEF_W-1:0] mag_t;

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage |X|^2 pipeline: squares registered in stage 1, their sum in stage 2.
module mag_sq_pipe
  import audio_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int W          = DEF_W,
  parameter int BIN_LENGTH = DEF_BIN_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic signed [IN_W-1:0] i_re,
  input  logic signed [IN_W-1:0] i_im,
  input  logic [BIN_LENGTH-1:0]  i_bin,
  input  logic                   i_last,
  output logic                   o_valid,
  output logic [W-1:0]           o_mag_sq,
  output logic [BIN_LENGTH-1:0]  o_bin,
  output logic                   o_last
);

  // A square is never negative, so the signed W-bit product is reused as unsigned.
  function automatic logic [W-1:0] square(input logic signed [IN_W-1:0] x);
    logic signed [W-1:0] x_ext;
    x_ext = W'(x);
    return x_ext * x_ext;
  endfunction

  logic                  r_vld_p1, r_vld_p2;
  logic                  r_last_p1, r_last_p2;
  logic [BIN_LENGTH-1:0] r_bin_p1, r_bin_p2;
  logic [W-1:0]          r_sq_re_p1, r_sq_im_p1;
  logic [W-1:0]          r_mag_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_bin_p1  <= '0;
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
      r_bin_p2  <= '0;
    end else begin
      // stage 1: squares
      r_vld_p1  <= i_valid;
      r_last_p1 <= i_valid & i_last;
      r_bin_p1  <= i_bin;
      // stage 2: sum
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
      r_bin_p2  <= r_bin_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_valid) begin
      r_sq_re_p1 <= square(i_re);
      r_sq_im_p1 <= square(i_im);
    end
    if (r_vld_p1) begin
      r_mag_p2 <= r_sq_re_p1 + r_sq_im_p1;
    end
  end

  assign o_valid  = r_vld_p2;
  assign o_mag_sq = r_vld_p2 ? r_mag_p2 : '0;
  assign o_bin    = r_bin_p2;
  assign o_last   = r_last_p2;

endmodule

// File: rtl/fft_mag_streamer.sv
// Frames FFT bins into exactly N magnitude-squared beats, padding short and truncating long frames.
module fft_mag_streamer
  import audio_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int IN_W       = DEF_IN_W,
  parameter int W          = DEF_W,
  parameter int BIN_LENGTH = DEF_BIN_LENGTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic signed [IN_W-1:0] sink_re,
  input  logic signed [IN_W-1:0] sink_im,
  input  logic                   err_clr,
  output logic                   mag_valid,
  output logic [W-1:0]           mag_sq,
  output logic [BIN_LENGTH-1:0]  bin_index,
  output logic                   frame_done,
  output logic                   err_short,
  output logic                   err_long
);

  localparam int                    GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIN_LENGTH-1:0] LAST_BIN = BIN_LENGTH'(N - 1);

  state_t                r_state, w_state_nxt;
  logic [BIN_LENGTH-1:0] r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0]      r_gap, w_gap_nxt;
  logic                  r_ready;
  logic                  r_err_short, r_err_long;

  logic                   w_accept;
  logic                   w_pipe_vld;
  logic signed [IN_W-1:0] w_pipe_re, w_pipe_im;
  logic [BIN_LENGTH-1:0]  w_pipe_bin;
  logic                   w_pipe_last;
  logic                   w_set_short, w_set_long;

  assign w_accept = sink_valid & r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_pipe_vld  = 1'b0;
    w_pipe_re   = '0;
    w_pipe_im   = '0;
    w_pipe_bin  = r_cnt;
    w_set_short = 1'b0;
    w_set_long  = 1'b0;
    case (r_state)
      IDLE, STREAM: begin
        // In IDLE only a sop beat opens a frame; inside STREAM sop is plain data.
        if (w_accept && (r_state == STREAM || sink_sop)) begin
          w_pipe_bin = (r_state == IDLE) ? '0 : r_cnt;
          w_pipe_vld = 1'b1;
          w_pipe_re  = sink_re;
          w_pipe_im  = sink_im;
          w_cnt_nxt  = w_pipe_bin + BIN_LENGTH'(1);
          if (w_pipe_bin == LAST_BIN) begin
            w_state_nxt = sink_eop ? GAP : DROP;
            w_set_long  = ~sink_eop;
          end else if (sink_eop) begin
            w_state_nxt = PAD;
            w_set_short = 1'b1;
          end else begin
            w_state_nxt = STREAM;
          end
        end
      end
      PAD: begin
        w_pipe_vld = 1'b1;
        w_cnt_nxt  = r_cnt + BIN_LENGTH'(1);
        if (r_cnt == LAST_BIN) w_state_nxt = GAP;
      end
      DROP: begin
        if (w_accept && sink_eop) w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_pipe_last = (w_pipe_bin == LAST_BIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_ready     <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_ready     <= (w_state_nxt == IDLE) || (w_state_nxt == STREAM) || (w_state_nxt == DROP);
      r_err_short <= w_set_short | (r_err_short & ~err_clr);
      r_err_long  <= w_set_long  | (r_err_long  & ~err_clr);
    end
  end

  mag_sq_pipe #(
    .IN_W       (IN_W),
    .W          (W),
    .BIN_LENGTH (BIN_LENGTH)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (reset),
    .i_valid  (w_pipe_vld),
    .i_re     (w_pipe_re),
    .i_im     (w_pipe_im),
    .i_bin    (w_pipe_bin),
    .i_last   (w_pipe_last),
    .o_valid  (mag_valid),
    .o_mag_sq (mag_sq),
    .o_bin    (bin_index),
    .o_last   (frame_done)
  );

  assign sink_ready = r_ready;
  assign err_short  = r_err_short;
  assign err_long   = r_err_long;

endmodule
